// File: rtl/accel_ctrl_pkg.sv
// Shared definitions for the accelerator host-command controller.
//   opcode_e   : host command opcodes carried in cmd_opcode[1:0]
//   reg_id_e   : accelerator register selectors (A, B, Y)
//   state_e    : controller FSM states
//   ID_MAGIC   : payload returned by the ID command
//   addr_width : lane-index width, never narrower than one bit
package accel_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ID    = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2,
    OP_START = 2'd3
  } opcode_e;

  typedef enum logic [1:0] {
    REG_A = 2'd0,
    REG_B = 2'd1,
    REG_Y = 2'd2
  } reg_id_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_RUN   = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  localparam logic [31:0] ID_MAGIC = 32'hDEADBEEF;

  function automatic int addr_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/accel_ctrl_timer.sv
// RUN-phase cycle counter for the command controller.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   clr          : restart the count at zero (wins over en)
//   en           : advance the count by one
//   count        : current count, zero-extended to DW
//   zero         : count is zero (first RUN cycle)
//   tc           : count has reached TIMEOUT-1 (last RUN cycle allowed)
module accel_ctrl_timer #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [DW-1:0] count,
  output logic          zero,
  output logic          tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Next count: clear has priority, otherwise advance while enabled.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CW{1'b0}};
    end else if (en) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= {CW{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = DW'(count_q);
  assign zero  = (count_q == {CW{1'b0}});
  assign tc    = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/accel_cmd_ctrl.sv
// Host-command sequencer for the accelerator register file and compute engine.
// Accepts one command at a time (WRITE, READ, START or ID) and returns exactly
// one response per accepted command.
//   clock, reset          : rising-edge clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (ready only while idle)
//   cmd_opcode/id/addr/data : command fields
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data/rsp_err      : response payload and error flag
//   acc_we/sel/addr/wdata : register write port toward the accelerator
//   acc_rdata             : combinational read of acc_sel/acc_addr
//   acc_start/acc_done    : compute start pulse and completion
//   busy                  : controller not idle
// All outputs are registered; they are computed from the next state.
module accel_cmd_ctrl
  import accel_ctrl_pkg::*;
#(
  parameter int  DW      = 32,
  parameter int  LANES   = 1,
  parameter int  TIMEOUT = 1024,
  localparam int AW      = addr_width(LANES)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [31:0]   cmd_opcode,
  input  logic [31:0]   cmd_id,
  input  logic [31:0]   cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          acc_we,
  output logic [1:0]    acc_sel,
  output logic [AW-1:0] acc_addr,
  output logic [DW-1:0] acc_wdata,
  input  logic [DW-1:0] acc_rdata,
  output logic          acc_start,
  input  logic          acc_done,
  output logic          busy
);

  state_e        state_q,     state_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q,      busy_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q,  rsp_data_d;
  logic          rsp_err_q,   rsp_err_d;
  logic          acc_we_q,    acc_we_d;
  logic [1:0]    acc_sel_q,   acc_sel_d;
  logic [AW-1:0] acc_addr_q,  acc_addr_d;
  logic [DW-1:0] acc_wdata_q, acc_wdata_d;
  logic          acc_start_q, acc_start_d;

  logic          fire_s;
  opcode_e       op_s;
  logic          cmd_legal_s;
  logic          timer_clr_s;
  logic          timer_en_s;
  logic [DW-1:0] run_cnt_s;
  logic          run_zero_s;
  logic          run_tc_s;

  accel_ctrl_timer #(
    .DW      (DW),
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (timer_clr_s),
    .en    (timer_en_s),
    .count (run_cnt_s),
    .zero  (run_zero_s),
    .tc    (run_tc_s)
  );

  // Command decode: full-width range checks so stray upper bits are rejected.
  always_comb begin
    fire_s      = cmd_valid && cmd_ready_q;
    op_s        = opcode_e'(cmd_opcode[1:0]);
    cmd_legal_s = (cmd_opcode[31:2] == 30'd0) &&
                  (cmd_id <= {30'd0, REG_Y}) &&
                  (cmd_addr < 32'(LANES));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    acc_sel_d   = acc_sel_q;
    acc_addr_d  = acc_addr_q;
    acc_wdata_d = acc_wdata_q;
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fire_s) begin
          acc_sel_d   = cmd_id[1:0];
          acc_addr_d  = cmd_addr[AW-1:0];
          acc_wdata_d = cmd_data;
          if (!cmd_legal_s) begin
            state_d    = ST_RESP;
            rsp_data_d = {DW{1'b0}};
            rsp_err_d  = 1'b1;
          end else begin
            case (op_s)
              OP_ID: begin
                state_d    = ST_RESP;
                rsp_data_d = DW'(ID_MAGIC);
                rsp_err_d  = 1'b0;
              end
              OP_WRITE: state_d = ST_WRITE;
              OP_READ:  state_d = ST_READ;
              OP_START: begin
                state_d     = ST_RUN;
                timer_clr_s = 1'b1;
              end
              default: begin
                state_d    = ST_RESP;
                rsp_data_d = {DW{1'b0}};
                rsp_err_d  = 1'b1;
              end
            endcase
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        state_d    = ST_RESP;
        rsp_data_d = {DW{1'b0}};
        rsp_err_d  = 1'b0;
      end
      ST_READ: begin
        state_d    = ST_RESP;
        rsp_data_d = acc_rdata;
        rsp_err_d  = 1'b0;
      end
      ST_RUN: begin
        timer_en_s = 1'b1;
        // acc_done is ignored in the start cycle; done beats timeout on a tie.
        if (acc_done && !run_zero_s) begin
          state_d    = ST_RESP;
          rsp_data_d = run_cnt_s;
          rsp_err_d  = 1'b0;
        end else if (run_tc_s) begin
          state_d    = ST_RESP;
          rsp_data_d = DW'(TIMEOUT);
          rsp_err_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Idle presents a quiet accelerator port and an empty response.
    if (state_d == ST_IDLE) begin
      acc_sel_d   = 2'd0;
      acc_addr_d  = {AW{1'b0}};
      acc_wdata_d = {DW{1'b0}};
      rsp_data_d  = {DW{1'b0}};
      rsp_err_d   = 1'b0;
    end else begin
      acc_sel_d   = acc_sel_d;
      acc_addr_d  = acc_addr_d;
      acc_wdata_d = acc_wdata_d;
    end

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    acc_we_d    = (state_d == ST_WRITE);
    acc_start_d = (state_q == ST_IDLE) && (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DW{1'b0}};
      rsp_err_q   <= 1'b0;
      acc_we_q    <= 1'b0;
      acc_sel_q   <= 2'd0;
      acc_addr_q  <= {AW{1'b0}};
      acc_wdata_q <= {DW{1'b0}};
      acc_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      acc_we_q    <= acc_we_d;
      acc_sel_q   <= acc_sel_d;
      acc_addr_q  <= acc_addr_d;
      acc_wdata_q <= acc_wdata_d;
      acc_start_q <= acc_start_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign acc_we    = acc_we_q;
  assign acc_sel   = acc_sel_q;
  assign acc_addr  = acc_addr_q;
  assign acc_wdata = acc_wdata_q;
  assign acc_start = acc_start_q;

endmodule

// File: tb/tb_accel_cmd_ctrl.sv
// Bench for accel_cmd_ctrl: directed corner cases followed by random commands,
// each checked against a command-level reference model (register contents,
// expected payload, error flag and response latency).
module tb_accel_cmd_ctrl;

  localparam int DW      = 32;
  localparam int LANES   = 4;
  localparam int TIMEOUT = 16;
  localparam int AW      = 2;

  logic          clock;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_opcode;
  logic [31:0]   cmd_id;
  logic [31:0]   cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          acc_we;
  logic [1:0]    acc_sel;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [DW-1:0] acc_rdata;
  logic          acc_start;
  logic          acc_done;
  logic          busy;

  accel_cmd_ctrl #(.DW(DW), .LANES(LANES), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_id     (cmd_id),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .acc_we     (acc_we),
    .acc_sel    (acc_sel),
    .acc_addr   (acc_addr),
    .acc_wdata  (acc_wdata),
    .acc_rdata  (acc_rdata),
    .acc_start  (acc_start),
    .acc_done   (acc_done),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accelerator stand-in: register storage plus a done generator.
  logic [31:0] mem [4][4] = '{default: 32'd0};
  logic        active     = 1'b0;
  int          since      = 0;
  int          plan_delay = 0;
  int          we_total   = 0;
  int          st_total   = 0;
  int          overlap    = 0;
  logic [1:0]  we_sel     = 2'd0;
  logic [1:0]  we_addr    = 2'd0;
  logic [31:0] we_data    = 32'd0;

  assign acc_rdata = mem[acc_sel][acc_addr];
  assign acc_done  = active && (plan_delay != 0) && (since >= plan_delay);

  always @(posedge clock) begin
    if (acc_we) begin
      mem[acc_sel][acc_addr] <= acc_wdata;
      we_total <= we_total + 1;
      we_sel   <= acc_sel;
      we_addr  <= acc_addr;
      we_data  <= acc_wdata;
    end
    if (acc_start) begin
      st_total <= st_total + 1;
      active   <= 1'b1;
      since    <= 1;
    end else if (active) begin
      since <= since + 1;
    end
    if (acc_we && acc_start) overlap <= overlap + 1;
  end

  // Reference register file, updated only from command fields.
  logic [31:0] ref_regs [4][4] = '{default: 32'd0};

  task automatic run_cmd(input string name, input logic [31:0] op, input logic [31:0] id,
                         input logic [31:0] addr, input logic [31:0] data,
                         input int dly, input int hold);
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
    int          exp_st;
    int          we0;
    int          st0;
    int          t;
    bit          legal;

    legal   = (op < 4) && (id < 3) && (addr < LANES);
    exp_we  = 0;
    exp_st  = 0;
    exp_data = 32'd0;
    exp_err  = 1'b1;
    exp_lat  = 1;
    if (legal) begin
      exp_err = 1'b0;
      case (op)
        0: begin exp_data = 32'hDEADBEEF; exp_lat = 1; end
        1: begin exp_data = 32'd0; exp_lat = 2; exp_we = 1; end
        2: begin exp_data = ref_regs[id][addr]; exp_lat = 2; end
        default: begin
          exp_st = 1;
          if (dly >= 1 && dly <= TIMEOUT - 1) begin
            exp_data = dly; exp_lat = dly + 2;
          end else begin
            exp_data = TIMEOUT; exp_err = 1'b1; exp_lat = TIMEOUT + 1;
          end
        end
      endcase
    end

    @(negedge clock);
    check_eq({name, ".ready"}, cmd_ready, 1'b1);
    we0        = we_total;
    st0        = st_total;
    plan_delay = dly;
    rsp_ready  = (hold == 0);
    cmd_opcode = op;
    cmd_id     = id;
    cmd_addr   = addr;
    cmd_data   = data;
    cmd_valid  = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    t = 1;
    while (rsp_valid !== 1'b1 && t < TIMEOUT + 8) begin
      @(posedge clock);
      #1;
      t++;
    end
    check_eq({name, ".lat"}, t, exp_lat);
    check_eq({name, ".data"}, rsp_data, exp_data);
    check_eq({name, ".err"}, rsp_err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock);
      #1;
      check_eq({name, ".hold_valid"}, rsp_valid, 1'b1);
      check_eq({name, ".hold_data"}, rsp_data, exp_data);
      check_eq({name, ".hold_err"}, rsp_err, exp_err);
      check_eq({name, ".hold_cmd_ready"}, cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clock);
    #1;
    check_eq({name, ".rsp_drop"}, rsp_valid, 1'b0);
    check_eq({name, ".idle_ready"}, cmd_ready, 1'b1);
    check_eq({name, ".idle_busy"}, busy, 1'b0);
    check_eq({name, ".idle_port"}, {acc_sel, acc_addr, acc_wdata}, 36'd0);
    check_eq({name, ".we_cnt"}, we_total - we0, exp_we);
    check_eq({name, ".start_cnt"}, st_total - st0, exp_st);
    if (exp_we == 1) begin
      check_eq({name, ".we_port"}, {we_sel, we_addr, we_data}, {id[1:0], addr[1:0], data});
      ref_regs[id][addr] = data;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    logic [31:0] op, id, addr;

    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_opcode = 32'd0;
    cmd_id     = 32'd0;
    cmd_addr   = 32'd0;
    cmd_data   = 32'd0;
    rsp_ready  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst.cmd_ready", cmd_ready, 1'b1);
    check_eq("rst.outs", {busy, rsp_valid, rsp_err, acc_we, acc_start}, 5'd0);
    check_eq("rst.data", {rsp_data, acc_sel, acc_addr, acc_wdata}, 68'd0);
    @(negedge clock);
    reset = 1'b1;

    // Directed cases.
    run_cmd("id",        32'd0, 32'd0, 32'd0, 32'd0,         0, 0);
    run_cmd("wr_a0",     32'd1, 32'd0, 32'd0, 32'h12345678,  0, 0);
    run_cmd("rd_a0",     32'd2, 32'd0, 32'd0, 32'd0,         0, 0);
    run_cmd("wr_y3",     32'd1, 32'd2, 32'd3, 32'hCAFEF00D,  0, 0);
    run_cmd("rd_y3",     32'd2, 32'd2, 32'd3, 32'd0,         0, 0);
    run_cmd("start5",    32'd3, 32'd0, 32'd0, 32'd0,         5, 0);
    run_cmd("start_to",  32'd3, 32'd0, 32'd0, 32'd0,         0, 0);
    run_cmd("start_max", 32'd3, 32'd0, 32'd0, 32'd0,   TIMEOUT - 1, 0);
    run_cmd("start_late",32'd3, 32'd0, 32'd0, 32'd0,   TIMEOUT, 0);
    run_cmd("start1",    32'd3, 32'd1, 32'd1, 32'd0,         1, 0);
    run_cmd("bad_op",    32'd7, 32'd0, 32'd0, 32'd0,         0, 0);
    run_cmd("bad_id",    32'd1, 32'd3, 32'd0, 32'h55AA55AA,  0, 0);
    run_cmd("bad_addr",  32'd1, 32'd0, LANES, 32'h0F0F0F0F,  0, 0);
    run_cmd("rd_hold",   32'd2, 32'd0, 32'd0, 32'd0,         0, 10);

    // Random commands.
    for (int n = 0; n < 60; n++) begin
      r    = $urandom_range(0, 9);
      id   = $urandom_range(0, 2);
      addr = $urandom_range(0, LANES - 1);
      case (r)
        0:       op = 32'd0;
        1, 2:    op = 32'd1;
        3, 4:    op = 32'd2;
        5, 6:    op = 32'd3;
        7: begin op = $urandom; if (op < 4) op = op + 32'd4; end
        8: begin op = $urandom_range(1, 2); id = $urandom_range(3, 1000); end
        default: begin op = $urandom_range(1, 2); addr = LANES + $urandom_range(0, 100); end
      endcase
      run_cmd($sformatf("rnd%0d", n), op, id, addr, $urandom,
              $urandom_range(0, TIMEOUT + 2), $urandom_range(0, 3));
    end

    // Reset while running: no response may appear afterwards.
    @(negedge clock);
    plan_delay = 0;
    rsp_ready  = 1'b1;
    cmd_opcode = 32'd3;
    cmd_id     = 32'd0;
    cmd_addr   = 32'd0;
    cmd_valid  = 1'b1;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rrun.busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("rrun.cmd_ready", cmd_ready, 1'b1);
    check_eq("rrun.outs", {busy, rsp_valid, acc_we, acc_start}, 4'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      @(posedge clock);
      #1;
      check_eq("rrun.no_rsp", rsp_valid, 1'b0);
    end
    run_cmd("post_rst_id", 32'd0, 32'd0, 32'd0, 32'd0, 0, 0);

    check_eq("we_start_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
